// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int REQ_CPU    = 0;
    localparam int REQ_DMA    = 1;
    localparam int CMD_ADDR_W = 7;
    localparam int CMD_DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // One accepted access, held for the single ACCESS cycle and beyond
    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic                  id;
    } cmd_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin grant logic with its last-grant pointer.
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter int FIRST_PRIO = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_id
);

    logic last_reg;

    // A requester wins when alone, or when it was not the last one served
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt[gi] = enable && req[gi] &&
                             (!req[NUM_REQ-1-gi] || (last_reg != 1'(gi)));
        end
    endgenerate

    assign gnt_id = gnt[REQ_DMA];

    // Pointer follows whoever was granted; reset makes FIRST_PRIO win the first tie
    always_ff @(posedge clock) begin
        if (reset) begin
            last_reg <= 1'(1 - FIRST_PRIO);
        end else if (|gnt) begin
            last_reg <= gnt_id;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU and DMA/debug ports.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = CMD_ADDR_W,
    parameter int DATA_W     = CMD_DATA_W,
    parameter int FIRST_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [DATA_W-1:0] mem_WriteData,
    input  logic [DATA_W-1:0] mem_ReadData
);

    state_t             state_reg;
    cmd_t               cmd_reg;
    logic [NUM_REQ-1:0] rvalid_reg;
    logic               err_reg;
    logic [DATA_W-1:0]  rdata_reg;
    logic               mem_read_reg;
    logic               mem_write_reg;

    logic [NUM_REQ-1:0] gnt;
    logic               gnt_id;
    logic               arb_enable;

    // Grants are only offered while idle and never during reset
    assign arb_enable = (state_reg == IDLE) && !reset;

    rr_arb2 #(
        .FIRST_PRIO(FIRST_PRIO)
    ) u_rr_arb2 (
        .clock (clock),
        .reset (reset),
        .enable(arb_enable),
        .req   ({req1, req0}),
        .gnt   (gnt),
        .gnt_id(gnt_id)
    );

    assign gnt0 = gnt[REQ_CPU];
    assign gnt1 = gnt[REQ_DMA];

    // Command register drives the memory bus, so address/data hold after the access
    assign mem_address   = cmd_reg.addr;
    assign mem_WriteData = cmd_reg.wdata;
    assign mem_MemRead   = mem_read_reg;
    assign mem_MemWrite  = mem_write_reg;
    assign rvalid0       = rvalid_reg[REQ_CPU];
    assign rvalid1       = rvalid_reg[REQ_DMA];
    assign err           = err_reg;
    assign rdata         = rdata_reg;

    // Accept in IDLE, perform exactly one memory cycle in ACCESS, respond on the next
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            cmd_reg       <= '0;
            rvalid_reg    <= '0;
            err_reg       <= 1'b0;
            rdata_reg     <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    rvalid_reg <= '0;
                    err_reg    <= 1'b0;
                    if (|gnt) begin
                        cmd_reg.we    <= gnt_id ? we1    : we0;
                        cmd_reg.addr  <= gnt_id ? addr1  : addr0;
                        cmd_reg.wdata <= gnt_id ? wdata1 : wdata0;
                        cmd_reg.id    <= gnt_id;
                        mem_write_reg <= gnt_id ? we1  : we0;
                        mem_read_reg  <= gnt_id ? !we1 : !we0;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b0;
                    if (!cmd_reg.we) begin
                        rdata_reg <= mem_ReadData;
                    end
                    rvalid_reg <= cmd_reg.id ? 2'b10 : 2'b01;
                    err_reg    <= |cmd_reg.addr[1:0];
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 32-word memory model.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [6:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err;
    logic [31:0] rdata;
    logic [6:0]  mem_address;
    logic        mem_MemRead, mem_MemWrite;
    logic [31:0] mem_WriteData, mem_ReadData;

    logic        preload;
    logic [31:0] tb_mem [0:31];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDR_W(7), .DATA_W(32), .FIRST_PRIO(0)
    ) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .err(err),
        .mem_address(mem_address), .mem_MemRead(mem_MemRead),
        .mem_MemWrite(mem_MemWrite), .mem_WriteData(mem_WriteData),
        .mem_ReadData(mem_ReadData)
    );

    // Memory model: combinational read, write only when MemWrite and not MemRead
    assign mem_ReadData = tb_mem[mem_address[6:2]];
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) tb_mem[i] <= 32'(i + 5);
        end else if (mem_MemWrite && !mem_MemRead) begin
            tb_mem[mem_address[6:2]] <= mem_WriteData;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; preload = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        repeat (3) tick();
        // Reset state
        check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_en", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
        check("rst_mem_addr", {25'd0, mem_address}, 32'd0);
        check("rst_mem_wd", mem_WriteData, 32'd0);
        check("pre_word0", tb_mem[0], 32'd5);
        reset = 1'b0; preload = 1'b0;

        // 1: CPU read of 0x04
        req0 = 1; we0 = 0; addr0 = 7'h04;
        #1;
        check("t1_gnt0", {31'd0, gnt0}, 32'd1);
        check("t1_gnt1", {31'd0, gnt1}, 32'd0);
        tick(); req0 = 0;
        #1;
        check("t1_mread", {30'd0, mem_MemRead, mem_MemWrite}, 32'd2);
        check("t1_maddr", {25'd0, mem_address}, 32'h04);
        check("t1_gnt_acc", {31'd0, gnt0}, 32'd0);
        tick();
        check("t1_rvalid", {30'd0, rvalid1, rvalid0}, 32'd1);
        check("t1_rdata", rdata, 32'd6);
        check("t1_err", {31'd0, err}, 32'd0);
        check("t1_mem_idle", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
        tick();
        check("t1_rv_pulse", {31'd0, rvalid0}, 32'd0);

        // 2: DMA write 0x08, then CPU read back
        req1 = 1; we1 = 1; addr1 = 7'h08; wdata1 = 32'hDEADBEEF;
        #1;
        check("t2_gnt1", {31'd0, gnt1}, 32'd1);
        tick(); req1 = 0;
        #1;
        check("t2_mwrite", {30'd0, mem_MemRead, mem_MemWrite}, 32'd1);
        check("t2_maddr", {25'd0, mem_address}, 32'h08);
        check("t2_mwdata", mem_WriteData, 32'hDEADBEEF);
        tick();
        check("t2_rvalid1", {30'd0, rvalid1, rvalid0}, 32'd2);
        check("t2_err", {31'd0, err}, 32'd0);
        req0 = 1; we0 = 0; addr0 = 7'h08;
        #1;
        check("t2_gnt_rv", {31'd0, gnt0}, 32'd1);
        tick(); req0 = 0;
        tick();
        check("t2_rvalid0", {30'd0, rvalid1, rvalid0}, 32'd1);
        check("t2_rdata", rdata, 32'hDEADBEEF);
        tick();

        // 3: both requesting continuously after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1; we0 = 0; addr0 = 7'h00;
        req1 = 1; we1 = 0; addr1 = 7'h04;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("t3_gnt0_c%0d", i), {31'd0, gnt0}, {31'd0, (i % 4) == 0});
            check($sformatf("t3_gnt1_c%0d", i), {31'd0, gnt1}, {31'd0, (i % 4) == 2});
            check($sformatf("t3_rv0_c%0d", i), {31'd0, rvalid0}, {31'd0, (i % 4) == 2});
            check($sformatf("t3_rv1_c%0d", i), {31'd0, rvalid1}, {31'd0, (i % 4) == 0 && i > 0});
            tick();
        end
        req0 = 0; req1 = 0;
        #1;
        check("t3_rv1_c8", {30'd0, rvalid1, rvalid0}, 32'd2);
        check("t3_rdata_c8", rdata, 32'd6);
        tick();

        // 4: misaligned read of 0x05
        req0 = 1; we0 = 0; addr0 = 7'h05;
        #1;
        check("t4_gnt0", {31'd0, gnt0}, 32'd1);
        tick(); req0 = 0;
        #1;
        check("t4_maddr", {25'd0, mem_address}, 32'h05);
        tick();
        check("t4_rvalid0", {31'd0, rvalid0}, 32'd1);
        check("t4_rdata", rdata, 32'd6);
        check("t4_err", {31'd0, err}, 32'd1);
        tick();
        check("t4_err_pulse", {31'd0, err}, 32'd0);

        // 5: reset during the ACCESS cycle of a write
        req0 = 1; we0 = 1; addr0 = 7'h00; wdata0 = 32'h12345678;
        #1;
        check("t5_gnt0", {31'd0, gnt0}, 32'd1);
        tick();
        req0 = 0; reset = 1'b1;
        #1;
        check("t5_mwrite", {31'd0, mem_MemWrite}, 32'd1);
        tick();
        check("t5_word0", tb_mem[0], 32'h12345678);
        check("t5_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        check("t5_err", {31'd0, err}, 32'd0);
        check("t5_rdata", rdata, 32'd0);
        check("t5_mem_en", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
        check("t5_maddr", {25'd0, mem_address}, 32'd0);
        check("t5_mwdata", mem_WriteData, 32'd0);
        reset = 1'b0;
        req0 = 1; we0 = 0; req1 = 1; we1 = 0;
        #1;
        check("t5_tie_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        tick();
        req0 = 0; req1 = 0;
        tick();
        check("t5_no_rv", {30'd0, rvalid1, rvalid0}, 32'd1);
        tick();

        // 6: DMA pulses req for one cycle while CPU holds the memory
        req0 = 1; we0 = 0; addr0 = 7'h00;
        #1;
        check("t6_gnt0", {31'd0, gnt0}, 32'd1);
        tick();
        req0 = 0; req1 = 1; we1 = 0; addr1 = 7'h04;
        #1;
        check("t6_gnt1_acc", {31'd0, gnt1}, 32'd0);
        tick();
        req1 = 0;
        #1;
        check("t6_gnt1_rv", {31'd0, gnt1}, 32'd0);
        check("t6_rvalid0", {31'd0, rvalid0}, 32'd1);
        check("t6_rdata", rdata, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t6_idle_c%0d", i), {30'd0, rvalid1, gnt1}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 128-byte data memory (7-bit byte address, 32-bit words, word index = address[6:2]) between two requesters.
- Requester 0 is the CPU load/store port; requester 1 is the DMA/debug port.
- Round-robin arbitration with req/gnt handshake; exactly one access is outstanding at a time.
- Drives the memory's MemRead/MemWrite/address/WriteData and returns registered read data with rvalid.

Parameters:
ADDR_W, 7, byte address width presented to the memory
DATA_W, 32, data word width
FIRST_PRIO, 0, requester that wins the first simultaneous request after reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 access request, held until gnt0
we0  in  1  requester 0: 1 = write, 0 = read
addr0  in  ADDR_W  requester 0 byte address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  requester 0 request accepted this cycle
rvalid0  out  1  requester 0 response pulse (read data or write done)
req1, we1, addr1, wdata1, gnt1, rvalid1  as above, for requester 1
rdata  out  DATA_W  registered read data, valid when rvalid0 or rvalid1 is high
err  out  1  pulses with rvalid when the accepted address had addr[1:0] != 0
mem_address  out  ADDR_W  memory address
mem_MemRead  out  1  memory read enable
mem_MemWrite  out  1  memory write enable
mem_WriteData  out  DATA_W  memory write data
mem_ReadData  in  DATA_W  memory combinational read data

Behaviour:
- Reset, sampled at a rising edge while reset=1:
  - state=IDLE, last-grant pointer = 1-FIRST_PRIO.
  - All outputs 0: gnt*, rvalid*, err, rdata, mem_*.
- State IDLE:
  - gnt is combinational: gntX = reqX and (no competing request, or X is the round-robin winner).
  - At most one gnt is high per cycle.
  - Round-robin winner on simultaneous requests = the requester not equal to the last-grant pointer.
  - On the edge where a gnt is high: latch we/addr/wdata/id into the command register, update the pointer to that id, go to ACCESS.
- State ACCESS, exactly one cycle:
  - mem_address = latched addr; mem_WriteData = latched wdata.
  - Write: mem_MemWrite=1, mem_MemRead=0. Read: mem_MemRead=1, mem_MemWrite=0.
  - Never assert both enables; the memory only writes when MemWrite and not MemRead.
  - gnt0 = gnt1 = 0.
  - At the closing edge: rdata <= mem_ReadData for reads (unchanged for writes), rvalid<id> <= 1, err <= (addr[1:0] != 0), go to IDLE.
- Latency:
  - Accept at edge N, memory access in cycle N+1, rvalid high in cycle N+2 for exactly one cycle.
  - A new gnt may be given in the same cycle rvalid is high.
  - Peak throughput: one access every 2 cycles.
- Outside ACCESS: mem_MemRead = mem_MemWrite = 0; mem_address and mem_WriteData hold their last values.
- Misaligned address: the access is still performed on word addr[6:2]; err is the only indication.
- Requests are level-held. A requester that drops req before gnt is simply not served; no state is kept for it.
- Same requester re-requesting back-to-back while the other also requests: it loses to the other (round-robin fairness, no starvation).
- Reset mid-operation:
  - Reset asserted during ACCESS: the memory write on that edge still occurs, because the enable was driven during the cycle.
  - No rvalid is produced; the block returns to IDLE with all outputs cleared.
- Reset asserted during the rvalid cycle: rvalid, err and rdata clear on the next edge.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, ACCESS};
  - REQ_CPU=0 and REQ_DMA=1 constants;
  - NUM_REQ=2;
  - a command struct {we, addr, wdata, id}.
- Sub-module rr_arb2: 2-input round-robin grant logic plus its pointer register. The FSM, command register and response logic stay in dmem_arbiter.

Test Plan:
1. After reset, with memory words 0..2 preloaded to 5, 6, 7: req0 read addr 0x04 -> gnt0 in cycle 0, mem_MemRead=1 with mem_address=0x04 in cycle 1, rvalid0=1 with rdata=6 in cycle 2, err=0.
2. req1 write addr 0x08 data 0xDEADBEEF, then req0 read 0x08 -> mem_MemWrite=1 and mem_MemRead=0 for one cycle, rvalid1 pulses; the following read returns rdata=0xDEADBEEF on rvalid0.
3. req0 and req1 both held high for 8 cycles after reset, FIRST_PRIO=0 -> grants alternate 0,1,0,1 on cycles 0,2,4,6; never both gnt high.
4. req0 read addr 0x05 -> word 1 is accessed, rdata=6, err=1 coincident with rvalid0.
5. reset=1 during the ACCESS cycle of a write of 0x12345678 to 0x00 -> word 0 becomes 0x12345678, no rvalid, all outputs 0 next cycle, next simultaneous request granted to requester 0.
6. req1 asserted one cycle then dropped before gnt, while req0 holds the resource -> no gnt1 and no rvalid1 ever issued.
